// File: rtl/spi_pkg.sv
// Shared SPI types and default frame/clock settings for spi_master and spi_slave benches.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    GAP  = 2'd3
  } spi_state_t;

  localparam int unsigned SPI_DATA_WIDTH = 8;
  localparam int unsigned SPI_CLK_DIV    = 50;

endpackage

// File: rtl/spi_half_period_cnt.sv
// Free-running SCLK half-period counter: wraps every CLK_DIV cycles, last marks the final cycle.
module spi_half_period_cnt
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic last
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // last is registered alongside cnt so it is high exactly while cnt == TERM
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt  <= '0;
      last <= 1'b0;
    end else if (last) begin
      cnt  <= '0;
      last <= 1'b0;
    end else begin
      cnt  <= cnt + CW'(1);
      last <= (cnt == TERM - CW'(1));
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first, single slave select; one frame per accepted start.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int unsigned CLK_DIV    = SPI_CLK_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  done,
  output logic                  busy,
  output logic                  SCLK,
  output logic                  MOSI,
  input  logic                  MISO,
  output logic                  SS_n
);

  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  if (CLK_DIV < 4) begin : g_bad_div
    $error("spi_master: CLK_DIV must be at least 4");
  end

  spi_state_t            state, state_nxt;
  logic                  pending, pending_nxt;
  logic [DATA_WIDTH-1:0] tx_shift, tx_shift_nxt;
  logic [DATA_WIDTH-1:0] rx_shift, rx_shift_nxt;
  logic [BW-1:0]         bit_cnt, bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] rx_data_nxt;
  logic                  done_nxt, busy_nxt, sclk_nxt, mosi_nxt, ss_n_nxt;
  logic                  miso_s1, miso_s2;
  logic                  half_last;
  logic                  cnt_clear_c;

  // Counter is held at zero while idle so LOW always starts a full half-period
  assign cnt_clear_c = (state == IDLE);

  spi_half_period_cnt #(.CLK_DIV(CLK_DIV)) u_half_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear_c),
    .last  (half_last)
  );

  // State and datapath registers, including the 2-FF MISO synchronizer
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= 1'b0;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      rx_data  <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      SCLK     <= 1'b0;
      MOSI     <= 1'b0;
      SS_n     <= 1'b1;
      miso_s1  <= 1'b0;
      miso_s2  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      tx_shift <= tx_shift_nxt;
      rx_shift <= rx_shift_nxt;
      bit_cnt  <= bit_cnt_nxt;
      rx_data  <= rx_data_nxt;
      done     <= done_nxt;
      busy     <= busy_nxt;
      SCLK     <= sclk_nxt;
      MOSI     <= mosi_nxt;
      SS_n     <= ss_n_nxt;
      miso_s1  <= MISO;
      miso_s2  <= miso_s1;
    end
  end

  // Next-state and next-output logic; start is captured one edge before the frame opens
  always_comb begin
    state_nxt    = state;
    pending_nxt  = pending;
    tx_shift_nxt = tx_shift;
    rx_shift_nxt = rx_shift;
    bit_cnt_nxt  = bit_cnt;
    rx_data_nxt  = rx_data;
    done_nxt     = 1'b0;
    busy_nxt     = busy;
    sclk_nxt     = SCLK;
    mosi_nxt     = MOSI;
    ss_n_nxt     = SS_n;

    case (state)
      IDLE: begin
        if (pending) begin
          pending_nxt = 1'b0;
          mosi_nxt    = tx_shift[DATA_WIDTH-1];
          ss_n_nxt    = 1'b0;
          sclk_nxt    = 1'b0;
          busy_nxt    = 1'b1;
          bit_cnt_nxt = '0;
          state_nxt   = LOW;
        end else if (start) begin
          pending_nxt  = 1'b1;
          tx_shift_nxt = tx_data;
        end
      end
      LOW: begin
        if (half_last) begin
          rx_shift_nxt = {rx_shift[DATA_WIDTH-2:0], miso_s2};
          sclk_nxt     = 1'b1;
          state_nxt    = HIGH;
        end
      end
      HIGH: begin
        if (half_last) begin
          sclk_nxt = 1'b0;
          if (bit_cnt < LAST_BIT) begin
            tx_shift_nxt = tx_shift << 1;
            mosi_nxt     = tx_shift[DATA_WIDTH-2];
            bit_cnt_nxt  = bit_cnt + BW'(1);
            state_nxt    = LOW;
          end else begin
            ss_n_nxt    = 1'b1;
            mosi_nxt    = 1'b0;
            rx_data_nxt = rx_shift;
            done_nxt    = 1'b1;
            state_nxt   = GAP;
          end
        end
      end
      GAP: begin
        if (half_last) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
